// File: rtl/mem_write_checker.sv
// Ordered store checker: compares core data-memory writes against a programmed table of DEPTH (address, data) pairs.
// Optional macro MEM_WRITE_CHECKER_IGNORE_EN adds IGN_ADDR, whose non-matching stores are skipped instead of failing.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16,
`ifdef MEM_WRITE_CHECKER_IGNORE_EN
    parameter logic [WIDTH-1:0] IGN_ADDR = 80,
`endif
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int MW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_we,
    input  logic [IW-1:0]    exp_idx,
    input  logic [WIDTH-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [MW-1:0]    match_cnt,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data,
    output logic [CW-1:0]    cycles
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t           r_state;
    logic             r_done, r_pass, r_fail;
    logic [1:0]       r_fail_code;
    logic [MW-1:0]    r_match_cnt;
    logic [WIDTH-1:0] r_fail_addr, r_fail_data;
    logic [CW-1:0]    r_cycles;
    logic [WIDTH-1:0] r_exp_addr [DEPTH];
    logic [WIDTH-1:0] r_exp_data [DEPTH];

    logic [IW-1:0] w_idx;
    logic          w_addr_eq, w_data_eq, w_hit, w_last, w_timeout, w_ignore;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_exp_addr[i] <= '0;
                r_exp_data[i] <= '0;
            end
        end else if (exp_we) begin
            r_exp_addr[exp_idx] <= exp_addr;
            r_exp_data[exp_idx] <= exp_data;
        end
    end

    // match_cnt stays below DEPTH while in RUN, so its low bits address the live entry
    assign w_idx     = r_match_cnt[IW-1:0];
    assign w_addr_eq = (dataadr == r_exp_addr[w_idx]);
    assign w_data_eq = (writedata == r_exp_data[w_idx]);
    assign w_hit     = memwrite && w_addr_eq && w_data_eq;
    assign w_last    = w_hit && (r_match_cnt == MW'(DEPTH - 1));
    assign w_timeout = (r_cycles == CW'(TIMEOUT - 1));
`ifdef MEM_WRITE_CHECKER_IGNORE_EN
    assign w_ignore  = memwrite && !w_hit && (dataadr == IGN_ADDR);
`else
    assign w_ignore  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= 2'd0;
            r_match_cnt <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_cycles    <= '0;
        end else if (start) begin
            r_state     <= S_RUN;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= 2'd0;
            r_match_cnt <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_cycles    <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cycles != '1)
                        r_cycles <= r_cycles + 1'b1;
                    // a store's own verdict always outranks the timeout
                    if (memwrite && !w_hit && !w_ignore) begin
                        r_state     <= S_FAIL;
                        r_done      <= 1'b1;
                        r_fail      <= 1'b1;
                        r_fail_code <= w_addr_eq ? 2'd1 : 2'd2;
                        r_fail_addr <= dataadr;
                        r_fail_data <= writedata;
                    end else if (w_last) begin
                        r_state     <= S_PASS;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b1;
                        r_match_cnt <= r_match_cnt + 1'b1;
                    end else begin
                        if (w_hit)
                            r_match_cnt <= r_match_cnt + 1'b1;
                        if (w_timeout) begin
                            r_state     <= S_FAIL;
                            r_done      <= 1'b1;
                            r_fail      <= 1'b1;
                            r_fail_code <= 2'd3;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_code = r_fail_code;
    assign match_cnt = r_match_cnt;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus random store streams against a rule-level reference model.
module tb_mem_write_checker;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;
    localparam int CW      = 8;
    localparam int IGN     = 80;
`ifdef MEM_WRITE_CHECKER_IGNORE_EN
    localparam bit IGN_ON  = 1'b1;
`else
    localparam bit IGN_ON  = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             exp_we;
    logic [1:0]       exp_idx;
    logic [WIDTH-1:0] exp_addr, exp_data;
    logic             start, memwrite;
    logic [WIDTH-1:0] dataadr, writedata;
    logic             done, pass, fail;
    logic [1:0]       fail_code;
    logic [2:0]       match_cnt;
    logic [WIDTH-1:0] fail_addr, fail_data;
    logic [CW-1:0]    cycles;

    mem_write_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data),
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [WIDTH-1:0] m_ea [DEPTH];
    logic [WIDTH-1:0] m_ed [DEPTH];
    bit          m_run, m_done, m_pass, m_fail;
    int unsigned m_code, m_cnt, m_cycles;
    logic [WIDTH-1:0] m_faddr, m_fdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < DEPTH; i++) begin m_ea[i] = '0; m_ed[i] = '0; end
        m_run = 0; m_done = 0; m_pass = 0; m_fail = 0;
        m_code = 0; m_cnt = 0; m_cycles = 0; m_faddr = '0; m_fdata = '0;
    endtask

    task automatic mdl_fail(input int unsigned code, input bit capture);
        m_run = 0; m_done = 1; m_fail = 1; m_code = code;
        if (capture) begin m_faddr = dataadr; m_fdata = writedata; end
    endtask

    // one clock edge of the rules, evaluated on the inputs present at that edge
    task automatic mdl_edge();
        int unsigned cyc0;
        bit decided;
        if (start) begin
            m_run = 1; m_done = 0; m_pass = 0; m_fail = 0;
            m_code = 0; m_cnt = 0; m_cycles = 0; m_faddr = '0; m_fdata = '0;
        end else if (m_run) begin
            cyc0 = m_cycles;
            if (m_cycles < 255) m_cycles++;
            decided = 0;
            if (memwrite) begin
                if (dataadr == m_ea[m_cnt] && writedata == m_ed[m_cnt]) begin
                    m_cnt++;
                    if (m_cnt == DEPTH) begin
                        m_run = 0; m_done = 1; m_pass = 1; decided = 1;
                    end
                end else if (!(IGN_ON && dataadr == IGN)) begin
                    mdl_fail((dataadr == m_ea[m_cnt]) ? 1 : 2, 1'b1);
                    decided = 1;
                end
            end
            if (!decided && cyc0 == TIMEOUT - 1) mdl_fail(3, 1'b0);
        end
        if (exp_we) begin m_ea[exp_idx] = exp_addr; m_ed[exp_idx] = exp_data; end
    endtask

    task automatic check_all();
        chk("done", 64'(done), 64'(m_done));
        chk("pass", 64'(pass), 64'(m_pass));
        chk("fail", 64'(fail), 64'(m_fail));
        chk("fail_code", 64'(fail_code), 64'(m_code));
        chk("match_cnt", 64'(match_cnt), 64'(m_cnt));
        chk("fail_addr", 64'(fail_addr), 64'(m_faddr));
        chk("fail_data", 64'(fail_data), 64'(m_fdata));
        chk("cycles", 64'(cycles), 64'(m_cycles));
    endtask

    task automatic cyc();
        @(posedge clk);
        mdl_edge();
        #1;
        check_all();
        start = 0; memwrite = 0; exp_we = 0;
    endtask

    task automatic prog(input int idx, input int a, input int d);
        exp_we = 1; exp_idx = 2'(idx); exp_addr = WIDTH'(a); exp_data = WIDTH'(d);
        cyc();
    endtask

    task automatic store(input int a, input int d);
        memwrite = 1; dataadr = WIDTH'(a); writedata = WIDTH'(d);
        cyc();
    endtask

    task automatic go();
        start = 1;
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic prog_std();
        prog(0, 0, 1); prog(1, 4, 2); prog(2, 8, 3); prog(3, 12, 4);
    endtask

    initial begin
        reset = 1; exp_we = 0; exp_idx = '0; exp_addr = '0; exp_data = '0;
        start = 0; memwrite = 0; dataadr = '0; writedata = '0;
        #1;
        mdl_reset();
        check_all();
        @(negedge clk); @(negedge clk);
        reset = 0;

        // in-order sequence passes
        prog_std(); go();
        store(0, 1); store(4, 2); store(8, 3); store(12, 4);
        chk("seq_pass", 64'(pass), 64'd1);
        idle(2);

        // data mismatch on the third store
        go();
        store(0, 1); store(4, 2); store(8, 9);
        chk("dmis_code", 64'(fail_code), 64'd1);
        chk("dmis_addr", 64'(fail_addr), 64'd8);
        chk("dmis_data", 64'(fail_data), 64'd9);
        chk("dmis_cnt", 64'(match_cnt), 64'd2);

        // address mismatch, and the ignore-address case
        prog(0, 84, 7); go();
        store(88, 7);
        chk("amis_code", 64'(fail_code), 64'd2);
        chk("amis_addr", 64'(fail_addr), 64'd88);
        go();
        store(80, 5);
        chk("ign_fail", 64'(fail), IGN_ON ? 64'd0 : 64'd1);
        store(84, 7);
        prog(0, 0, 1);

        // timeout with no stores
        go();
        idle(TIMEOUT);
        chk("to_code", 64'(fail_code), 64'd3);
        chk("to_cycles", 64'(cycles), 64'(TIMEOUT));

        // final matching store lands in the timeout cycle
        go();
        idle(TIMEOUT - 4);
        store(0, 1); store(4, 2); store(8, 3); store(12, 4);
        chk("to_race_pass", 64'(pass), 64'd1);

        // start after PASS re-arms
        go();
        chk("rearm_done", 64'(done), 64'd0);
        chk("rearm_cnt", 64'(match_cnt), 64'd0);

        // asynchronous reset mid-run after two matches
        store(0, 1); store(4, 2);
        #3;
        reset = 1;
        #1;
        mdl_reset();
        check_all();
        @(negedge clk);
        reset = 0;
        prog_std(); go();
        store(0, 1); store(4, 2); store(8, 3); store(12, 4);
        chk("post_rst_pass", 64'(pass), 64'd1);

        // random streams
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < DEPTH; i++)
                prog(i, $urandom_range(0, 7) * 4, $urandom_range(0, 3));
            go();
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 99) < 45) begin
                    memwrite = 1;
                    if (m_cnt < DEPTH && $urandom_range(0, 99) < 75) begin
                        dataadr = m_ea[m_cnt]; writedata = m_ed[m_cnt];
                    end else begin
                        dataadr = ($urandom_range(0, 4) == 0) ? WIDTH'(IGN)
                                                              : WIDTH'($urandom_range(0, 7) * 4);
                        writedata = WIDTH'($urandom_range(0, 3));
                    end
                end
                if ($urandom_range(0, 99) < 5) begin
                    exp_we = 1; exp_idx = 2'($urandom_range(0, DEPTH - 1));
                    exp_addr = WIDTH'($urandom_range(0, 7) * 4);
                    exp_data = WIDTH'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 99) < 2) start = 1;
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
